// File: rtl/axi_slv_mem_pkg.sv
// Shared constants, FSM state types and response helper for the AXI slave memory.
package axi_slv_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // A decode error outranks a protocol (wlast) error.
    function automatic logic [1:0] resp_sel(input logic slverr, input logic decerr);
        logic [1:0] resp;
        if (decerr) begin
            resp = RESP_DECERR;
        end else if (slverr) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi_slv_mem_if.sv
// AXI4 write/read channel bundle with master and slave views.
interface axi_slv_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/axi_slv_mem_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port that holds when re=0.
module axi_slv_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic [DATA_W/8-1:0]      we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] q_r;

    // Byte-lane writes; contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we[b]) begin
                mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read returns pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (re) begin
            q_r <= mem_r[raddr];
        end
    end

    assign rdata = q_r;
endmodule

// File: rtl/axi_slv_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) FSMs over a dual-port RAM.
module axi_slv_mem
    import axi_slv_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic         aclk,
    input  logic         areset,
    axi_slv_mem_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB_W  = $clog2(STRB_W);
    localparam int WA_W   = ADDR_W - LSB_W;
    localparam int RA_W   = $clog2(DEPTH);
    localparam logic [WA_W:0]   DEPTH_L = DEPTH[WA_W:0];
    localparam logic [WA_W-1:0] WA_ONE  = {{(WA_W-1){1'b0}}, 1'b1};

    w_state_t          w_state_r, w_next_s;
    logic [ID_W-1:0]   w_id_r;
    logic [WA_W-1:0]   w_addr_r;
    logic [7:0]        w_len_r, w_cnt_r;
    logic              w_slverr_r, w_decerr_r;
    logic              awready_r, wready_r, bvalid_r;
    logic [1:0]        bresp_r;
    logic              aw_hs_s, w_hs_s, b_hs_s, w_final_s, w_in_range_s;
    logic [STRB_W-1:0] ram_we_s;

    r_state_t          r_state_r, r_next_s;
    logic [ID_W-1:0]   r_id_r;
    logic [WA_W-1:0]   r_addr_r;
    logic [7:0]        r_len_r;
    logic [8:0]        r_cnt_r;
    logic              s1_valid_r, s1_last_r, s1_oor_r;
    logic              arready_r, rvalid_r, rlast_r;
    logic [1:0]        rresp_r;
    logic [DATA_W-1:0] rdata_r, ram_q_s;
    logic              ar_hs_s, r_hs_s, out_adv_s, issue_s, r_in_range_s;

    assign aw_hs_s      = bus.awvalid & awready_r;
    assign w_hs_s       = bus.wvalid & wready_r;
    assign b_hs_s       = bus.bready & bvalid_r;
    assign w_final_s    = (w_cnt_r == w_len_r);
    assign w_in_range_s = ({1'b0, w_addr_r} < DEPTH_L);
    assign ram_we_s     = (w_hs_s && w_in_range_s) ? bus.wstrb : {STRB_W{1'b0}};

    // Write FSM next state.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
            W_DATA:  if (w_hs_s && w_final_s) w_next_s = W_RESP; else w_next_s = W_DATA;
            W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write state, burst tracking and registered AW/W/B outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_r  <= W_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            w_id_r     <= {ID_W{1'b0}};
            w_addr_r   <= {WA_W{1'b0}};
            w_len_r    <= 8'd0;
            w_cnt_r    <= 8'd0;
            w_slverr_r <= 1'b0;
            w_decerr_r <= 1'b0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_IDLE);
            wready_r  <= (w_next_s == W_DATA);
            bvalid_r  <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                w_id_r     <= bus.awid;
                w_addr_r   <= bus.awaddr[ADDR_W-1:LSB_W];
                w_len_r    <= bus.awlen;
                w_cnt_r    <= 8'd0;
                w_slverr_r <= 1'b0;
                w_decerr_r <= 1'b0;
            end else if (w_hs_s) begin
                w_addr_r   <= w_addr_r + WA_ONE;
                w_cnt_r    <= w_cnt_r + 8'd1;
                w_slverr_r <= w_slverr_r | (bus.wlast != w_final_s);
                w_decerr_r <= w_decerr_r | ~w_in_range_s;
                if (w_final_s) begin
                    bresp_r <= resp_sel(w_slverr_r | (bus.wlast != w_final_s),
                                        w_decerr_r | ~w_in_range_s);
                end
            end
        end
    end

    // Read pipeline: issue -> RAM stage (s1) -> output register; stalls propagate backwards.
    assign ar_hs_s      = bus.arvalid & arready_r;
    assign r_hs_s       = rvalid_r & bus.rready;
    assign out_adv_s    = ~rvalid_r | bus.rready;
    assign r_in_range_s = ({1'b0, r_addr_r} < DEPTH_L);
    assign issue_s      = (r_state_r == R_DATA) && (r_cnt_r <= {1'b0, r_len_r}) &&
                          (~s1_valid_r | out_adv_s);

    // Read FSM next state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_r) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read state, beat issue and registered AR/R outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b0;
            r_id_r     <= {ID_W{1'b0}};
            r_addr_r   <= {WA_W{1'b0}};
            r_len_r    <= 8'd0;
            r_cnt_r    <= 9'd0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_oor_r   <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= {DATA_W{1'b0}};
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_IDLE);
            if (ar_hs_s) begin
                r_id_r   <= bus.arid;
                r_addr_r <= bus.araddr[ADDR_W-1:LSB_W];
                r_len_r  <= bus.arlen;
                r_cnt_r  <= 9'd0;
            end else if (issue_s) begin
                r_addr_r <= r_addr_r + WA_ONE;
                r_cnt_r  <= r_cnt_r + 9'd1;
            end
            if (issue_s) begin
                s1_valid_r <= 1'b1;
                s1_last_r  <= (r_cnt_r[7:0] == r_len_r);
                s1_oor_r   <= ~r_in_range_s;
            end else if (out_adv_s) begin
                s1_valid_r <= 1'b0;
            end
            if (out_adv_s) begin
                rvalid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    rdata_r <= s1_oor_r ? {DATA_W{1'b0}} : ram_q_s;
                    rresp_r <= s1_oor_r ? RESP_DECERR : RESP_OKAY;
                    rlast_r <= s1_last_r;
                end else begin
                    rlast_r <= 1'b0;
                end
            end
        end
    end

    axi_slv_mem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (aclk),
        .we    (ram_we_s),
        .waddr (w_addr_r[RA_W-1:0]),
        .wdata (bus.wdata),
        .re    (issue_s),
        .raddr (r_addr_r[RA_W-1:0]),
        .rdata (ram_q_s)
    );

    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bid     = w_id_r;
    assign bus.bresp   = bresp_r;
    assign bus.arready = arready_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rid     = r_id_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;
    assign bus.rlast   = rlast_r;
endmodule

// File: doc/axi_slv_mem.md
AXI_SLV_MEM -- requirements
Module: axi_slv_mem

Interface
REQ-001 ADDR_W, 16, byte address width.
REQ-002 DATA_W, 32, data width; SHALL be 32 or 64.
REQ-003 ID_W, 4, transaction ID width.
REQ-004 DEPTH, 1024, memory depth in DATA_W words.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 awid/awaddr/awlen  in  ID_W/ADDR_W/8  write address, ID, beats-1.
REQ-008 awvalid in 1, awready out 1  AW handshake.
REQ-009 wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data, byte enables, last flag.
REQ-010 wvalid in 1, wready out 1  W handshake.
REQ-011 bid/bresp  out  ID_W/2  write response.
REQ-012 bvalid out 1, bready in 1  B handshake.
REQ-013 arid/araddr/arlen  in  ID_W/ADDR_W/8  read address, ID, beats-1.
REQ-014 arvalid in 1, arready out 1  AR handshake.
REQ-015 rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data beat.
REQ-016 rvalid out 1, rready in 1  R handshake.

Function
REQ-017 Bursts SHALL be INCR, full-width only; address low bits below word size ignored; word address increments by 1 per beat, modulo 2^ADDR_W.
REQ-018 Write FSM SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE; AW handshake latches awid, word address, awlen and enters W_DATA.
REQ-019 In W_DATA wready SHALL be 1; each W handshake writes the bytes enabled by wstrb and advances the address; after beat awlen+1 the FSM enters W_RESP.
REQ-020 bvalid SHALL assert the cycle after the final W handshake and hold, with bid and bresp stable, until bready; W_IDLE is re-entered the cycle after the B handshake.
REQ-021 bresp SHALL be OKAY (00), SLVERR (10) if wlast is absent on the final beat or present earlier, or DECERR (11) if any beat's word address >= DEPTH (DECERR wins); out-of-range beats are not written.
REQ-022 Read FSM SHALL be R_IDLE -> R_DATA -> R_IDLE; arready=1 only in R_IDLE; AR handshake latches arid, word address and arlen.
REQ-023 First rvalid SHALL assert 2 cycles after the AR handshake; with rready held high, beats SHALL issue back-to-back (1 per cycle).
REQ-024 While rvalid=1 and rready=0, rdata/rresp/rlast/rid SHALL hold stable.
REQ-025 rlast SHALL be 1 on beat arlen+1 only; the FSM returns to R_IDLE the cycle after that handshake.
REQ-026 Out-of-range read beats SHALL return rdata=0 and rresp=DECERR; in-range beats return OKAY.
REQ-027 Read and write paths SHALL be independent; a read of a word written in the same cycle returns the old data.
REQ-028 awlen=0 and arlen=0 (single beat) and arlen=255 SHALL be supported.

Reset
REQ-029 While areset=1: awready, wready, bvalid, arready, rvalid, rlast = 0, bresp = rresp = 00, FSMs in IDLE.
REQ-030 First cycle after areset deasserts: awready=arready=1.
REQ-031 areset mid-burst SHALL abort the burst with no response; memory contents SHALL be preserved.

Structure
REQ-032 Package axi_slv_mem_pkg SHALL hold the RESP_OKAY/RESP_SLVERR/RESP_DECERR constants and the write/read state enums.
REQ-033 Sub-module axi_slv_mem_ram SHALL implement a simple dual-port RAM with byte-enable write port and 1-cycle registered read port.

Verification
REQ-034 AW 0x0010 len=3, 4 beats 0xA0..0xA3, wstrb=F -> B OKAY; AR 0x0010 len=3 -> 0xA0..0xA3, rlast on beat 4.
REQ-035 Write wstrb=0x3 data 0x12345678 over 0xFFFFFFFF at 0x0020 -> read returns 0xFFFF5678.
REQ-036 AR len=7 with rready toggling 1/0 each cycle -> 8 beats, no loss or duplication, data held stable while stalled.
REQ-037 AW len=1 with wlast on beat 1 -> bresp=10; AW at word DEPTH-1 len=1 -> bresp=11, word DEPTH-1 written, out-of-range beat dropped.
REQ-038 areset for 1 cycle during beat 2 of a len=3 read -> rvalid=0 next cycle, arready=1 after release, prior data intact.
